param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 16: entry count, SHALL be a power of two >= 2; all DEPTH entries SHALL be usable.
REQ-003 Parameter AF_THRESH, default DEPTH-2: almost_full threshold, range 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 2: almost_empty threshold, range 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 w_en  in  1  write request.
REQ-009 data_in  in  WIDTH  write data.
REQ-010 r_en  in  1  read request (FWFT=1: pop acknowledge).
REQ-011 clr_err  in  1  clears sticky error flags.
REQ-012 data_out  out  WIDTH  read data.
REQ-013 valid  out  1  data_out holds a valid popped or head word.
REQ-014 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-015 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-017 Write SHALL be accepted iff w_en && !full; accepted word stored at write pointer, pointer incremented modulo DEPTH.
REQ-018 Read SHALL be accepted iff r_en && !empty; read pointer incremented modulo DEPTH.
REQ-019 Simultaneous accepted read and write: both occur, count unchanged; no write-through when empty, no write when full even if read accepted that cycle.
REQ-020 count SHALL be +1 on write-only, -1 on read-only, unchanged otherwise; it SHALL never exceed DEPTH or go below 0.
REQ-021 full = (count == DEPTH); empty = (count == 0); both derived from registered count, no pointer-comparison ambiguity.
REQ-022 almost_full = (count >= AF_THRESH); almost_empty = (count <= AE_THRESH).
REQ-023 FWFT=0: on accepted read, data_out SHALL load the head word and valid SHALL be 1 for exactly the next cycle; otherwise data_out holds its value and valid = 0.
REQ-024 FWFT=1: data_out SHALL present the head word and valid = !empty continuously; r_en with valid pops; a word written into an empty FIFO appears on data_out the cycle after the write.
REQ-025 Ordering SHALL be strict first-in first-out across pointer wrap-around.
REQ-026 overflow SHALL set when w_en && full; underflow SHALL set when r_en && empty; dropped operations change no other state.
REQ-027 clr_err SHALL clear both sticky flags; a set condition in the same cycle SHALL take priority over clear.

Reset
REQ-028 While rst = 1: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, valid 0, data_out 0, overflow 0, underflow 0.
REQ-029 w_en, r_en, clr_err SHALL be ignored while rst = 1; reset mid-operation discards all contents; memory array need not be reset.

Verification (DEPTH=16, WIDTH=8, AF_THRESH=14, AE_THRESH=2)
REQ-030 Reset, then write 0x00..0x0F -> count 16, full 1, almost_full asserted at count 14, no overflow; 17th write -> overflow 1, count stays 16.
REQ-031 From full, read 16 (FWFT=0) -> data_out 0x00..0x0F, each one cycle after r_en with valid 1; empty 1 and almost_empty asserted at count 2; extra read -> underflow 1.
REQ-032 Fill 10, read 10, write 12 more, read all -> wrap-around order preserved, count ends 0.
REQ-033 At count 8, w_en and r_en together for 5 cycles -> count stays 8, output order correct; at full, both set -> read only, count 15.
REQ-034 FWFT=1: write 0xA5 to empty -> next cycle data_out 0xA5, valid 1; r_en -> valid 0, empty 1.
REQ-035 Mid-stream rst at count 7 -> next cycle count 0, empty 1, valid 0; clr_err with simultaneous overflow event -> overflow remains 1.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with a count-derived status, registered or first-word-fall-through read, sticky errors.
// Registered mode: data 1 cycle after r_en. FWFT mode: head combinational. Dropped ops flagged, never stall.
module param_sync_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_en,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     r_en,
   input  logic                     clr_err,
   output logic [WIDTH-1:0]         data_out,
   output logic                     valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_acc;
   logic             rd_acc;

   // Acceptance uses only the registered flags, so a read never frees a slot for a write in the same cycle.
   assign wr_acc       = w_en && !full;
   assign rd_acc       = r_en && !empty;
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   always_ff @(posedge clk) begin
      if (!rst && wr_acc)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // A new error event wins over a clear arriving in the same cycle.
         if (w_en && full)
            overflow <= 1'b1;
         else if (clr_err)
            overflow <= 1'b0;
         if (r_en && empty)
            underflow <= 1'b1;
         else if (clr_err)
            underflow <= 1'b0;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = empty ? '0 : mem[rd_ptr];
         assign valid    = !empty;
      end else begin : g_reg
         logic [WIDTH-1:0] dout_q;
         logic             vld_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               dout_q <= '0;
               vld_q  <= 1'b0;
            end else begin
               vld_q <= rd_acc;
               if (rd_acc)
                  dout_q <= mem[rd_ptr];
            end
         end
         assign data_out = dout_q;
         assign valid    = vld_q;
      end
   endgenerate
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: registered-read instance u0 and FWFT instance u1.
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
module tb_param_sync_fifo;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       w_en = 0, r_en = 0, clr_err = 0;
   logic [7:0] data_in = '0;
   logic [7:0] data_out;
   logic       valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0] count;

   logic       w_en1 = 0, r_en1 = 0, clr_err1 = 0;
   logic [7:0] data_in1 = '0;
   logic [7:0] data_out1;
   logic       valid1, full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
   logic [4:0] count1;

   int checks = 0;
   int failures = 0;
   logic [7:0] q[$];
   logic [7:0] e;

   always #5 clk = ~clk;

   param_sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u0 (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .clr_err(clr_err),
      .data_out(data_out), .valid(valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow));

   param_sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u1 (
      .clk(clk), .rst(rst), .w_en(w_en1), .data_in(data_in1), .r_en(r_en1), .clr_err(clr_err1),
      .data_out(data_out1), .valid(valid1), .full(full1), .empty(empty1),
      .almost_full(almost_full1), .almost_empty(almost_empty1), .count(count1),
      .overflow(overflow1), .underflow(underflow1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] d);
      w_en = 1; data_in = d; tick(); w_en = 0;
      q.push_back(d);
   endtask

   task automatic rd_chk(input string tag);
      r_en = 1; tick(); r_en = 0;
      e = q.pop_front();
      chk({tag, "_data"}, int'(data_out), int'(e));
      chk({tag, "_valid"}, int'(valid), 1);
   endtask

   initial begin
      tick(); tick();
      rst = 0;
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_ae", int'(almost_empty), 1);
      chk("rst_af", int'(almost_full), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_dout", int'(data_out), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_unf", int'(underflow), 0);
      chk("rst_fwft_valid", int'(valid1), 0);

      // Fill to full, watching the status flags step by step
      for (int i = 0; i < 16; i++) begin
         w_en = 1; data_in = 8'(i); tick();
         chk("fill_count", int'(count), i + 1);
         chk("fill_af", int'(almost_full), (i + 1 >= 14) ? 1 : 0);
         chk("fill_full", int'(full), (i + 1 == 16) ? 1 : 0);
      end
      w_en = 0;
      chk("fill_no_ovf", int'(overflow), 0);
      w_en = 1; data_in = 8'h55; tick(); w_en = 0;
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_count", int'(count), 16);
      clr_err = 1; tick(); clr_err = 0;
      chk("ovf_clr", int'(overflow), 0);

      // Drain in order
      for (int i = 0; i < 16; i++) begin
         r_en = 1; tick();
         chk("drain_data", int'(data_out), i);
         chk("drain_valid", int'(valid), 1);
         chk("drain_count", int'(count), 15 - i);
         chk("drain_ae", int'(almost_empty), (15 - i <= 2) ? 1 : 0);
         chk("drain_empty", int'(empty), (i == 15) ? 1 : 0);
      end
      r_en = 0; tick();
      chk("idle_valid", int'(valid), 0);
      chk("idle_hold", int'(data_out), 8'h0F);
      r_en = 1; tick(); r_en = 0;
      chk("unf_set", int'(underflow), 1);
      chk("unf_valid", int'(valid), 0);
      chk("unf_count", int'(count), 0);
      clr_err = 1; tick(); clr_err = 0;
      chk("unf_clr", int'(underflow), 0);

      // Wrap-around
      for (int i = 0; i < 10; i++) wr(8'h10 + 8'(i));
      for (int i = 0; i < 10; i++) rd_chk("wrap1");
      for (int i = 0; i < 12; i++) wr(8'h20 + 8'(i));
      chk("wrap_count12", int'(count), 12);
      for (int i = 0; i < 12; i++) rd_chk("wrap2");
      chk("wrap_end_count", int'(count), 0);

      // Simultaneous read and write at half occupancy
      for (int i = 0; i < 8; i++) wr(8'h30 + 8'(i));
      for (int i = 0; i < 5; i++) begin
         w_en = 1; r_en = 1; data_in = 8'h40 + 8'(i); tick();
         q.push_back(8'h40 + 8'(i));
         e = q.pop_front();
         chk("rw_data", int'(data_out), int'(e));
         chk("rw_count", int'(count), 8);
      end
      w_en = 0; r_en = 0;
      for (int i = 0; i < 8; i++) wr(8'h50 + 8'(i));
      chk("rw_full", int'(full), 1);
      // At full a simultaneous write is refused while the read proceeds
      w_en = 1; r_en = 1; data_in = 8'hEE; tick(); w_en = 0; r_en = 0;
      e = q.pop_front();
      chk("full_rw_data", int'(data_out), int'(e));
      chk("full_rw_count", int'(count), 15);
      for (int i = 0; i < 15; i++) rd_chk("full_rw_drain");
      chk("full_rw_empty", int'(empty), 1);

      // FWFT instance
      w_en1 = 1; data_in1 = 8'hA5; tick(); w_en1 = 0;
      chk("fwft_data", int'(data_out1), 8'hA5);
      chk("fwft_valid", int'(valid1), 1);
      r_en1 = 1; tick(); r_en1 = 0;
      chk("fwft_pop_valid", int'(valid1), 0);
      chk("fwft_pop_empty", int'(empty1), 1);
      w_en1 = 1; data_in1 = 8'hB1; tick(); data_in1 = 8'hB2; tick(); w_en1 = 0;
      chk("fwft_head1", int'(data_out1), 8'hB1);
      r_en1 = 1; tick(); r_en1 = 0;
      chk("fwft_head2", int'(data_out1), 8'hB2);
      chk("fwft_count", int'(count1), 1);

      // Mid-stream reset
      for (int i = 0; i < 7; i++) wr(8'h60 + 8'(i));
      chk("pre_rst_count", int'(count), 7);
      r_en = 1; tick(); r_en = 0;
      chk("pre_rst_valid", int'(valid), 1);
      rst = 1; w_en = 1; data_in = 8'h99; tick();
      chk("mid_rst_count", int'(count), 0);
      chk("mid_rst_empty", int'(empty), 1);
      chk("mid_rst_valid", int'(valid), 0);
      chk("mid_rst_dout", int'(data_out), 0);
      tick();
      chk("rst_ignores_wen", int'(count), 0);
      rst = 0; w_en = 0;
      q.delete();
      wr(8'h77);
      rd_chk("post_rst");

      // Overflow set wins over a same-cycle clear
      for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
      w_en = 1; clr_err = 1; data_in = 8'hCC; tick();
      chk("ovf_priority", int'(overflow), 1);
      w_en = 0; tick(); clr_err = 0;
      chk("ovf_clr2", int'(overflow), 0);
      chk("ovf_clr2_count", int'(count), 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
